// File: rtl/uop_fetch_queue.sv
// rtl/uop_fetch_queue.sv - micro-op fetch front end: upc, uop buffer read, DEPTH-entry queue to decode
module uop_fetch_queue #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [WIDTH-1:0]         rom_data,
  input  logic                     halt,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_uop,
  output logic [ADDR_W-1:0]        out_upc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = WIDTH + ADDR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] upc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic              pop;
  logic              push;

  // Valid depends only on occupancy, so decode may derive ready from it.
  assign out_valid = (cnt != '0);
  assign pop       = out_valid && out_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push      = !redirect && !halt && ((cnt != FULL_CNT) || pop);
  assign rom_addr  = upc;
  assign count     = cnt;
  assign {out_uop, out_upc} = mem[rd_ptr];

  // Micro-PC: redirect wins over halt; each fetch advances by one with natural wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc <= '0;
    end else if (redirect) begin
      upc <= redirect_pc;
    end else if (push) begin
      upc <= upc + ADDR_W'(1);
    end
  end

  // Queue pointers and occupancy; redirect discards everything, including the entry behind a popped head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage holds the fetched word with the address it came from; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {rom_data, upc};
    end
  end

endmodule

// File: tb/tb_uop_fetch_queue.sv
// tb/tb_uop_fetch_queue.sv - self-checking bench for uop_fetch_queue with a queue-based reference model
module tb_uop_fetch_queue;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] rom_addr;
  logic [WIDTH-1:0]  rom_data;
  logic              halt;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_uop;
  logic [ADDR_W-1:0] out_upc;
  logic [2:0]        count;

  int total = 0;
  int bad   = 0;
  logic chk_en;

  // reference model: queue of fetch addresses plus the model micro-PC
  logic [ADDR_W-1:0] mq [$];
  logic [ADDR_W-1:0] m_upc;

  logic [ADDR_W-1:0] wrap_exp [4];

  uop_fetch_queue #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .halt(halt),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_uop(out_uop),
    .out_upc(out_upc),
    .count(count)
  );

  // uop buffer: word i holds 0x1000 + i
  assign rom_data = 32'h1000 + 32'(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // model update on each active edge, cleared asynchronously by reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_upc = '0;
    end else begin
      bit m_pop;
      bit m_push;
      m_pop  = (mq.size() != 0) && out_ready;
      m_push = !redirect && !halt && ((mq.size() < DEPTH) || m_pop);
      if (redirect) begin
        mq.delete();
        m_upc = redirect_pc;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back(m_upc);
          m_upc = m_upc + 7'd1;
        end
      end
    end
  end

  // compare DUT against model every cycle, mid-period
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("cyc_count", 32'(count), 32'(mq.size()));
      chk("cyc_rom_addr", 32'(rom_addr), 32'(m_upc));
      if (mq.size() != 0) begin
        chk("cyc_out_upc", 32'(out_upc), 32'(mq[0]));
        chk("cyc_out_uop", out_uop, 32'h1000 + 32'(mq[0]));
      end
    end
  end

  initial begin
    wrap_exp[0] = 7'd126;
    wrap_exp[1] = 7'd127;
    wrap_exp[2] = 7'd0;
    wrap_exp[3] = 7'd1;
    reset = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1; chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk_en = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    // streaming with out_ready=1
    cyc(5);
    chk("stream_upc", 32'(out_upc), 32'd4);
    chk("stream_uop", out_uop, 32'h1004);
    chk("stream_count", 32'(count), 32'd1);

    // backpressure fills the queue and stalls upc
    out_ready = 1'b0;
    cyc(6);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_rom_addr", 32'(rom_addr), 32'd8);
    chk("fill_head", 32'(out_upc), 32'd4);

    // full queue with pop: push and pop each cycle
    out_ready = 1'b1;
    cyc(4);
    chk("full_count", 32'(count), 32'd4);
    chk("full_head", 32'(out_upc), 32'd8);
    chk("full_rom_addr", 32'(rom_addr), 32'd12);

    // drop to 3 entries, then redirect with a pop in the same cycle
    halt = 1'b1;
    cyc(1);
    chk("pre_redir_count", 32'(count), 32'd3);
    halt = 1'b0; redirect = 1'b1; redirect_pc = 7'h40;
    cyc(1);
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_rom_addr", 32'(rom_addr), 32'h40);
    redirect = 1'b0;
    cyc(1);
    chk("redir_head", 32'(out_upc), 32'h40);
    chk("redir_uop", out_uop, 32'h1040);

    // upc wrap at 2^ADDR_W
    redirect = 1'b1; redirect_pc = 7'd126;
    cyc(1);
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("wrap_upc", 32'(out_upc), 32'(wrap_exp[i]));
    end

    // two entries queued, then halt drains them with upc frozen
    out_ready = 1'b0;
    cyc(1);
    chk("halt_pre_count", 32'(count), 32'd2);
    out_ready = 1'b1; halt = 1'b1;
    cyc(5);
    chk("halt_valid", 32'(out_valid), 32'd0);
    chk("halt_count", 32'(count), 32'd0);
    chk("halt_rom_addr", 32'(rom_addr), 32'd3);
    redirect = 1'b1; redirect_pc = 7'h20;
    cyc(1);
    chk("halt_redir_addr", 32'(rom_addr), 32'h20);
    redirect = 1'b0;
    cyc(2);
    chk("halt_hold_valid", 32'(out_valid), 32'd0);
    chk("halt_hold_addr", 32'(rom_addr), 32'h20);
    halt = 1'b0;
    cyc(1);
    chk("resume_valid", 32'(out_valid), 32'd1);
    chk("resume_upc", 32'(out_upc), 32'h20);
    chk("resume_uop", out_uop, 32'h1020);

    // asynchronous reset mid-stream
    cyc(3);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_rom_addr", 32'(rom_addr), 32'd0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;

    // fill from empty after reset
    out_ready = 1'b0;
    cyc(4);
    chk("fill0_count", 32'(count), 32'd4);
    chk("fill0_rom_addr", 32'(rom_addr), 32'd4);
    chk("fill0_head", 32'(out_upc), 32'd0);
    cyc(2);
    chk("fill0_stall_addr", 32'(rom_addr), 32'd4);
    out_ready = 1'b1;
    cyc(4);
    chk("drain_head", 32'(out_upc), 32'd4);
    chk("drain_count", 32'(count), 32'd4);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
